// File: rtl/audio_voice_scheduler_if.sv
// Trigger request and sample-ROM bus between the voice scheduler (slave) and its
// environment (master: trigger source plus synchronous sample ROM).
interface audio_voice_scheduler_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 16
);
  logic                  trig_valid;
  logic [ADDR_WIDTH-1:0] trig_addr;
  logic [ADDR_WIDTH-1:0] trig_len;
  logic                  trig_ack;
  logic                  trig_drop;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;

  modport master (
    output trig_valid, trig_addr, trig_len, rom_data,
    input  trig_ack, trig_drop, rom_addr
  );

  modport slave (
    input  trig_valid, trig_addr, trig_len, rom_data,
    output trig_ack, trig_drop, rom_addr
  );
endinterface

// File: rtl/audio_voice_scheduler.sv
// Time-shares one synchronous sample ROM between NUM_VOICES voices and mixes one
// saturated sample per sample_tick. Define AUDIO_VOICE_STEAL_EN to steal a busy voice.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for sample_tick
// S_SCAN   | check voice v; skip it in one cycle if inactive
// S_ISSUE  | drive rom_addr = base[v] + pos[v]
// S_WAIT   | hold rom_addr for ROM_LATENCY cycles
// S_ACCUM  | add rom_data to the accumulator, advance voice v
// S_OUTPUT | publish the saturated mix, pulse mix_valid
module audio_voice_scheduler #(
  parameter int NUM_VOICES  = 4,
  parameter int ADDR_WIDTH  = 18,
  parameter int DATA_WIDTH  = 16,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_tick,
  audio_voice_scheduler_if.slave bus,
  output logic [DATA_WIDTH-1:0] mix_out,
  output logic                  mix_valid,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic                  tick_overrun
);
  localparam int VW   = $clog2(NUM_VOICES);
  localparam int ACCW = DATA_WIDTH + VW;
  localparam int LW   = $clog2(ROM_LATENCY + 1);
  localparam logic [VW-1:0] LAST_V = VW'(NUM_VOICES - 1);
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(VW+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(VW+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_ISSUE, S_WAIT, S_ACCUM, S_OUTPUT} state_t;

  state_t                 state;
  logic [VW-1:0]          v;
  logic [LW-1:0]          wait_cnt;
  logic signed [ACCW-1:0] acc;
  logic [ADDR_WIDTH-1:0]  base [NUM_VOICES];
  logic [ADDR_WIDTH-1:0]  len  [NUM_VOICES];
  logic [ADDR_WIDTH-1:0]  pos  [NUM_VOICES];

  logic                   trig_go;
  logic                   alloc_hit;
  logic [VW-1:0]          alloc_idx;
  logic [ADDR_WIDTH-1:0]  pos_inc;
  logic signed [ACCW-1:0] data_ext;
  logic [DATA_WIDTH-1:0]  sat_mix;
  logic                   suppress;

  assign trig_go  = bus.trig_valid && (bus.trig_len != '0);
  assign pos_inc  = pos[v] + 1'b1;
  assign data_ext = {{VW{bus.rom_data[DATA_WIDTH-1]}}, bus.rom_data};

  always_comb begin
    if (acc > SAT_MAX)      sat_mix = SAT_MAX[DATA_WIDTH-1:0];
    else if (acc < SAT_MIN) sat_mix = SAT_MIN[DATA_WIDTH-1:0];
    else                    sat_mix = acc[DATA_WIDTH-1:0];
  end

  // Allocation looks only at registered flags, so a voice retiring this cycle stays busy.
  always_comb begin
    alloc_hit = 1'b0;
    alloc_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!voice_active[i]) begin
        alloc_hit = 1'b1;
        alloc_idx = VW'(i);
      end
    end
`ifdef AUDIO_VOICE_STEAL_EN
    if (!alloc_hit) begin
      logic [ADDR_WIDTH-1:0] best_pos;
      alloc_hit = 1'b1;
      best_pos  = pos[0];
      for (int i = 1; i < NUM_VOICES; i++) begin
        if (pos[i] > best_pos) begin
          best_pos  = pos[i];
          alloc_idx = VW'(i);
        end
      end
    end
`endif
  end

`ifdef AUDIO_VOICE_STEAL_EN
  // Remembers that the voice being fetched was reloaded, so ACCUM leaves it alone.
  logic stolen_q;
  assign suppress = stolen_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stolen_q <= 1'b0;
    end else if (state == S_ACCUM) begin
      stolen_q <= 1'b0;
    end else if (trig_go && (&voice_active) && (alloc_idx == v) &&
                 (state == S_ISSUE || state == S_WAIT)) begin
      stolen_q <= 1'b1;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      v            <= '0;
      wait_cnt     <= '0;
      acc          <= '0;
      mix_out      <= '0;
      mix_valid    <= 1'b0;
      voice_active <= '0;
      tick_overrun <= 1'b0;
      bus.trig_ack  <= 1'b0;
      bus.trig_drop <= 1'b0;
      bus.rom_addr  <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        base[i] <= '0;
        len[i]  <= '0;
        pos[i]  <= '0;
      end
    end else begin
      mix_valid     <= 1'b0;
      bus.trig_ack  <= 1'b0;
      bus.trig_drop <= 1'b0;
      if (sample_tick && state != S_IDLE) tick_overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (sample_tick) begin
            acc   <= '0;
            v     <= '0;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (voice_active[v])  state <= S_ISSUE;
          else if (v == LAST_V) state <= S_OUTPUT;
          else                  v     <= v + 1'b1;
        end
        S_ISSUE: begin
          bus.rom_addr <= base[v] + pos[v];
          wait_cnt     <= LW'(ROM_LATENCY - 1);
          state        <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == '0) state    <= S_ACCUM;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        S_ACCUM: begin
          acc <= acc + data_ext;
          if (!suppress) begin
            pos[v] <= pos_inc;
            if (pos_inc == len[v]) voice_active[v] <= 1'b0;
          end
          if (v == LAST_V) begin
            state <= S_OUTPUT;
          end else begin
            v     <= v + 1'b1;
            state <= S_SCAN;
          end
        end
        S_OUTPUT: begin
          mix_out   <= sat_mix;
          mix_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // A reload placed after the ACCUM update takes priority for the same voice.
      if (trig_go) begin
        if (alloc_hit) begin
          base[alloc_idx]         <= bus.trig_addr;
          len[alloc_idx]          <= bus.trig_len;
          pos[alloc_idx]          <= '0;
          voice_active[alloc_idx] <= 1'b1;
          bus.trig_ack            <= 1'b1;
        end else begin
          bus.trig_drop <= 1'b1;
        end
      end
    end
  end
endmodule
